// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_scheduler
//  Description : Round-robin scheduler sharing one combinational ALU among
//                NUM_REQ requesters. Registers the winner's opcode/operands
//                toward the ALU, captures result/flags one cycle later and
//                returns them on a valid/ready response channel tagged with
//                the requester ID.
//                Optional feature macro: ALU_SCHED_BACK2BACK_EN
//                (arbitrate on the response handshake cycle, skipping IDLE).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*4-1:0]   req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*5-1:0]   req_shift,
    output logic [3:0]             alu_opcode,
    output logic [WIDTH-1:0]       alu_input1,
    output logic [WIDTH-1:0]       alu_input2,
    output logic [4:0]             alu_shift,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [3:0]             alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [3:0]             rsp_flags,
    output logic                   rsp_err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [3:0]       r_alu_opcode;
    logic [WIDTH-1:0] r_alu_input1;
    logic [WIDTH-1:0] r_alu_input2;
    logic [4:0]       r_alu_shift;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;

    logic             w_arb;
    logic [IDW-1:0]   w_base;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_gnt;
    logic             w_any;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [4:0]       w_sel_shift;

`ifdef ALU_SCHED_BACK2BACK_EN
    // Arbitration window: IDLE, or the response handshake cycle (search restarts after the finished grant)
    assign w_arb  = (r_state == c_ST_IDLE) || ((r_state == c_ST_RESP) && rsp_ready);
    assign w_base = (r_state == c_ST_RESP) ? r_gnt : r_ptr;
`else
    assign w_arb  = (r_state == c_ST_IDLE);
    assign w_base = r_ptr;
`endif

    // Round-robin search from base+1; descending loop so the nearest valid requester wins last
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = '0;
        w_cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = IDW'((int'(w_base) + i) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_any = 1'b1;
                w_gnt = w_cand;
            end
        end
    end

    // Operand mux for the current grant, constant-index slices only
    always_comb begin
        w_sel_op    = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_shift = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_sel_op    = req_opcode[i*4 +: 4];
                w_sel_a     = req_a[i*WIDTH +: WIDTH];
                w_sel_b     = req_b[i*WIDTH +: WIDTH];
                w_sel_shift = req_shift[i*5 +: 5];
            end
        end
    end

    // One-hot accept pulse, only in the arbitration window and never while in reset
    always_comb begin
        req_ready = '0;
        if (!rst && w_arb && w_any) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Scheduler FSM: accept -> issue to ALU -> hold response until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_ptr        <= IDW'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_gnt;
                        r_alu_opcode <= w_sel_op;
                        r_alu_input1 <= w_sel_a;
                        r_alu_input2 <= w_sel_b;
                        r_alu_shift  <= w_sel_shift;
                        r_state      <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= alu_flags;
                    r_rsp_id     <= r_gnt;
                    r_rsp_err    <= (r_alu_opcode > 4'd9);
                    r_rsp_valid  <= 1'b1;
                    r_state      <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_ptr       <= r_gnt;
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
`ifdef ALU_SCHED_BACK2BACK_EN
                        if (w_any) begin
                            r_gnt        <= w_gnt;
                            r_alu_opcode <= w_sel_op;
                            r_alu_input1 <= w_sel_a;
                            r_alu_input2 <= w_sel_b;
                            r_alu_shift  <= w_sel_shift;
                            r_state      <= c_ST_ISSUE;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_input1 = r_alu_input1;
    assign alu_input2 = r_alu_input2;
    assign alu_shift  = r_alu_shift;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rr_scheduler
//  Description : Directed self-checking bench for alu_rr_scheduler with a
//                small behavioural ALU (5=ADD, 6=SUB, others give 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 64;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*4-1:0]     req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*5-1:0]     req_shift;
    logic [3:0]               alu_opcode;
    logic [WIDTH-1:0]         alu_input1;
    logic [WIDTH-1:0]         alu_input2;
    logic [4:0]               alu_shift;
    logic [WIDTH-1:0]         alu_result;
    logic [3:0]               alu_flags;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic [3:0]               rsp_flags;
    logic                     rsp_err;

    int tests;
    int fails;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shift  (req_shift),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_shift  (alu_shift),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags {carry, overflow, sign, zero}
    logic [WIDTH:0] w_sum;
    always_comb begin
        w_sum      = '0;
        alu_result = '0;
        case (alu_opcode)
            4'd5: w_sum = {1'b0, alu_input1} + {1'b0, alu_input2};
            4'd6: w_sum = {1'b0, alu_input1} - {1'b0, alu_input2};
            default: w_sum = '0;
        endcase
        alu_result = w_sum[WIDTH-1:0];
        alu_flags  = {w_sum[WIDTH], 1'b0, alu_result[WIDTH-1], (alu_result == '0)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] sh);
        req_opcode[i*4 +: 4]     = op;
        req_a[i*WIDTH +: WIDTH]  = a;
        req_b[i*WIDTH +: WIDTH]  = b;
        req_shift[i*5 +: 5]      = sh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w;
    int first_cyc;
    int second_cyc;
    int exp_second;
    logic [NUM_REQ-1:0] clr;
    logic [IDW-1:0] id_first;
    logic [IDW-1:0] id_second;

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        req_shift  = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("rst_alu_input1", alu_input1, 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        rst = 1'b0;
        tick();

        // T1: single ADD on requester 0
        set_req(0, 4'd5, 64'd5, 64'd7, 5'd17);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("t1_req_ready_N", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;
        chk("t1_req_ready_N1", 64'(req_ready), 64'd0);
        chk("t1_rsp_valid_N1", 64'(rsp_valid), 64'd0);
        chk("t1_alu_opcode", 64'(alu_opcode), 64'd5);
        chk("t1_alu_input1", alu_input1, 64'd5);
        chk("t1_alu_input2", alu_input2, 64'd7);
        chk("t1_alu_shift", 64'(alu_shift), 64'd17);
        tick();
        chk("t1_rsp_valid_N2", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_result", rsp_result, 64'd12);
        chk("t1_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("t1_rsp_id", 64'(rsp_id), 64'd0);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        chk("t1_rsp_valid_done", 64'(rsp_valid), 64'd0);

        // T2: all requesters held valid from reset, order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'd5, 64'(i * 10), 64'd1, 5'd0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!rsp_valid && w < 10) begin
                tick();
                w++;
            end
            chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("t2_rsp_id", 64'(rsp_id), 64'(k % 4));
            chk("t2_rsp_result", rsp_result, 64'((k % 4) * 10 + 1));
            if (k == 4) req_valid = 4'b0000;
            tick();
        end
        tick();
        chk("t2_idle_after", 64'(rsp_valid), 64'd0);

        // T3: response back-pressure for 5 cycles (ptr=0, req2 alone)
        set_req(2, 4'd5, 64'd100, 64'd23, 5'd0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("t3_req_ready_N", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0010;
        chk("t3_req_ready_issue", 64'(req_ready), 64'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_result", rsp_result, 64'd123);
            chk("t3_hold_id", 64'(rsp_id), 64'd2);
            chk("t3_no_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("t3_valid_6th", 64'(rsp_valid), 64'd1);
        chk("t3_result_6th", rsp_result, 64'd123);
        tick();
        chk("t3_released", 64'(rsp_valid), 64'd0);

        // T4: unsupported opcode 12
        set_req(0, 4'd12, 64'd3, 64'd4, 5'd0);
        req_valid = 4'b0001;
        #1;
        chk("t4_req_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t4_rsp_err", 64'(rsp_err), 64'd1);
        chk("t4_rsp_result", rsp_result, 64'd0);
        chk("t4_rsp_flags", 64'(rsp_flags), 64'b0001);
        chk("t4_rsp_id", 64'(rsp_id), 64'd0);
        tick();

        // T5: reset during ISSUE, then req0 wins over pending req2
        set_req(0, 4'd5, 64'd40, 64'd2, 5'd0);
        req_valid = 4'b0001;
        #1;
        chk("t5_req_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0100;
        rst = 1'b1;
        tick();
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t5_rst_rsp_valid2", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("t5_req0_wins", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0100;
        tick();
        chk("t5_rsp_id0", 64'(rsp_id), 64'd0);
        chk("t5_rsp_result0", rsp_result, 64'd42);
        tick();
        chk("t5_req2_next", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("t5_rsp_id2", 64'(rsp_id), 64'd2);
        tick();

        // T6: two queued requests (ptr=2 -> order 0 then 1)
        set_req(0, 4'd5, 64'd1, 64'd1, 5'd0);
        set_req(1, 4'd6, 64'd9, 64'd4, 5'd0);
        req_valid  = 4'b0011;
        first_cyc  = -1;
        second_cyc = -1;
        id_first   = '0;
        id_second  = '0;
        #1;
        chk("t6_first_grant", 64'(req_ready), 64'b0001);
        for (int t = 0; t < 9; t++) begin
            if (rsp_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = t;
                    id_first  = rsp_id;
                end else if (second_cyc < 0) begin
                    second_cyc = t;
                    id_second  = rsp_id;
                end
            end
            clr = req_ready;
            tick();
            req_valid = req_valid & ~clr;
        end
`ifdef ALU_SCHED_BACK2BACK_EN
        exp_second = 4;
`else
        exp_second = 5;
`endif
        chk("t6_first_cycle", 64'(first_cyc), 64'd2);
        chk("t6_second_cycle", 64'(second_cyc), 64'(exp_second));
        chk("t6_first_id", 64'(id_first), 64'd0);
        chk("t6_second_id", 64'(id_second), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
